seg7_bcd_encoder: RTL and testbench

//  Reverse of our BCD-to-7-segment decoder: samples a 7-bit segment bus driven
//  by an external/asynchronous display driver and recovers the BCD digit.

---
 rtl/seg7_bcd_encoder_pkg.sv | 54 +++++
 rtl/seg7_bcd_encoder_stability_filter.sv | 50 +++++
 rtl/seg7_bcd_encoder.sv | 94 +++++++++
 tb/tb_seg7_bcd_encoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_bcd_encoder_pkg.sv
// Shared 7-segment code constants, FSM encoding
// and the pattern classifier for the segment-bus readback path.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h1F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SETTLE = 1'b0,
    STABLE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    K_DIGIT   = 2'd0,
    K_BLANK   = 2'd1,
    K_INVALID = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] digit;
  } class_t;

  function automatic class_t classify(input logic [6:0] s);
    class_t r;
    r.kind  = K_DIGIT;
    r.digit = 4'd0;
    unique case (s)
      SEG_0:     r.digit = 4'd0;
      SEG_1:     r.digit = 4'd1;
      SEG_2:     r.digit = 4'd2;
      SEG_3:     r.digit = 4'd3;
      SEG_4:     r.digit = 4'd4;
      SEG_5:     r.digit = 4'd5;
      SEG_6:     r.digit = 4'd6;
      SEG_7:     r.digit = 4'd7;
      SEG_8:     r.digit = 4'd8;
      SEG_9:     r.digit = 4'd9;
      SEG_BLANK: r.kind  = K_BLANK;
      default:   r.kind  = K_INVALID;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_encoder_stability_filter.sv
// Synchronises the async segment bus and tracks how long
// the synced pattern has been unchanged.
module seg7_stability_filter #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic [6:0] cand_o,
  output logic       changed_o,
  output logic       stable_hit_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_q;
  logic [6:0]       seg_s_q;
  logic [6:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;

  assign changed_o    = (seg_s_q != cand_q);
  assign stable_hit_o = !changed_o && (cnt_q == CNT_MAX);
  assign cand_o       = cand_q;

  // Two-flop synchroniser; nothing else touches the raw bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      seg_s_q <= '0;
    end else begin
      sync1_q <= seg_i;
      seg_s_q <= sync1_q;
    end
  end

  // Reload candidate on change, else count up and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (changed_o) begin
      cand_q <= seg_s_q;
      cnt_q  <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_bcd_encoder.sv
// Recovers the BCD digit from a debounced 7-segment bus
// and pulses code_valid once per newly committed pattern.
module seg7_bcd_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       hold,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err,
  output logic       code_valid
);

  logic [6:0] cand;
  logic       changed;
  logic       stable_hit;

  state_e     state_q, state_d;
  logic [6:0] committed_q;
  logic       have_commit_q;
  logic [3:0] bcd_q;
  logic       blank_q;
  logic       err_q;
  logic       valid_q;
  logic       commit;
  class_t     cls;

  seg7_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filt (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_i       (seg),
    .cand_o      (cand),
    .changed_o   (changed),
    .stable_hit_o(stable_hit)
  );

  assign cls = classify(cand);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SETTLE;
    else        state_q <= state_d;
  end

  // Next state: any change resettles; a hit leaves SETTLE unless held off.
  always_comb begin
    state_d = state_q;
    if (changed) begin
      state_d = SETTLE;
    end else if (state_q == SETTLE && stable_hit) begin
      if (commit || !hold) state_d = STABLE;
    end
  end

  // Commit decision: new stable pattern, not frozen, differs from last one.
  always_comb begin
    commit = 1'b0;
    if (state_q == SETTLE && stable_hit && !hold)
      commit = !have_commit_q || (cand != committed_q);
  end

  // Output and committed-pattern registers, loaded only on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed_q   <= '0;
      have_commit_q <= 1'b0;
      bcd_q         <= '0;
      blank_q       <= 1'b0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= commit;
      if (commit) begin
        committed_q   <= cand;
        have_commit_q <= 1'b1;
        blank_q       <= (cls.kind == K_BLANK);
        err_q         <= (cls.kind == K_INVALID);
        if (cls.kind == K_DIGIT) bcd_q <= cls.digit;
      end
    end
  end

  assign bcd        = bcd_q;
  assign blank      = blank_q;
  assign err        = err_q;
  assign code_valid = valid_q;

endmodule

// File: tb/tb_seg7_bcd_encoder.sv
// Directed self-checking bench for seg7_bcd_encoder
// with hand-computed latencies and decoded values.
module tb_seg7_bcd_encoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic       hold;
  logic [3:0] bcd;
  logic       blank;
  logic       err;
  logic       code_valid;

  int vectors;
  int miscompares;
  int pulses;
  int first;
  int dbl;
  int xs;
  logic [6:0] codes [10];

  seg7_bcd_encoder #(
    .STABLE_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .hold      (hold),
    .bcd       (bcd),
    .blank     (blank),
    .err       (err),
    .code_valid(code_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n edges; counts pulses, first pulse edge (1-based), back-to-back pulses, X samples.
  task automatic run(input int n, output int p, output int f, output int d, output int x);
    logic prev;
    prev = 1'b0;
    p = 0; f = -1; d = 0; x = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if ($isunknown({bcd, blank, err, code_valid})) x++;
      if (code_valid === 1'b1) begin
        p++;
        if (f < 0) f = i;
        if (prev) d++;
      end
      prev = code_valid;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    codes[0] = 7'h7E; codes[1] = 7'h30; codes[2] = 7'h6D; codes[3] = 7'h79;
    codes[4] = 7'h33; codes[5] = 7'h5B; codes[6] = 7'h1F; codes[7] = 7'h70;
    codes[8] = 7'h7F; codes[9] = 7'h7B;
    rst_n = 1'b0;
    seg   = 7'h00;
    hold  = 1'b0;
    step();
    step();
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_flags", int'({blank, err, code_valid}), 0);

    // 1: first commit latency, then silence while steady
    rst_n = 1'b1;
    seg   = 7'h7E;
    run(19, pulses, first, dbl, xs);
    chk("t1_latency", first, 19);
    chk("t1_out", int'({bcd, blank, err}), 0);
    run(40, pulses, first, dbl, xs);
    chk("t1_quiet", pulses, 0);

    // 2: blank first so digit 0 is new, then sweep 0..9
    seg = 7'h00;
    run(40, pulses, first, dbl, xs);
    chk("t2_blank_pulse", pulses, 1);
    for (int k = 0; k < 10; k++) begin
      seg = codes[k];
      run(40, pulses, first, dbl, xs);
      chk($sformatf("t2_pulses_%0d", k), pulses, 1);
      chk($sformatf("t2_lat_%0d", k), first, 19);
      chk($sformatf("t2_bcd_%0d", k), int'({bcd, blank, err}), k << 2);
    end

    // 3: glitch returning to committed value
    seg = 7'h5B;
    run(40, pulses, first, dbl, xs);
    chk("t3_commit5", int'(bcd), 5);
    seg = 7'h6D;
    run(10, pulses, first, dbl, xs);
    chk("t3_glitch", pulses, 0);
    seg = 7'h5B;
    run(40, pulses, first, dbl, xs);
    chk("t3_return", pulses, 0);
    chk("t3_bcd", int'(bcd), 5);

    // 4: blank and invalid keep bcd
    seg = 7'h00;
    run(40, pulses, first, dbl, xs);
    chk("t4_blank_p", pulses, 1);
    chk("t4_blank", int'({bcd, blank, err}), (5 << 2) | 2);
    seg = 7'h4F;
    run(40, pulses, first, dbl, xs);
    chk("t4_err_p", pulses, 1);
    chk("t4_err", int'({bcd, blank, err}), (5 << 2) | 1);

    // 5: hold freezes, release commits on next edge
    seg = 7'h30;
    run(40, pulses, first, dbl, xs);
    chk("t5_bcd1", int'(bcd), 1);
    hold = 1'b1;
    seg  = 7'h79;
    run(50, pulses, first, dbl, xs);
    chk("t5_held", pulses, 0);
    chk("t5_held_bcd", int'(bcd), 1);
    hold = 1'b0;
    run(1, pulses, first, dbl, xs);
    chk("t5_release", pulses, 1);
    chk("t5_bcd3", int'(bcd), 3);
    run(30, pulses, first, dbl, xs);
    chk("t5_after", pulses, 0);

    // 6: reset mid-settle discards progress
    seg = 7'h1F;
    run(11, pulses, first, dbl, xs);
    chk("t6_pre", pulses, 0);
    rst_n = 1'b0;
    step();
    chk("t6_rst_bcd", int'(bcd), 0);
    chk("t6_rst_flags", int'({blank, err, code_valid}), 0);
    rst_n = 1'b1;
    seg   = 7'h33;
    run(40, pulses, first, dbl, xs);
    chk("t6_latency", first, 19);
    chk("t6_bcd4", int'({bcd, blank, err}), 4 << 2);

    // random async toggling: no commits, no X
    xs = 0;
    dbl = 0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      #($urandom_range(1, 8));
      seg = 7'($urandom);
      if ($isunknown({bcd, blank, err, code_valid})) xs++;
      if (code_valid === 1'b1) pulses++;
    end
    chk("t6_rand_x", xs, 0);
    chk("t6_rand_pulses", pulses, 0);
    seg = 7'h7B;
    run(40, pulses, first, dbl, xs);
    chk("t6_settle_p", pulses, 1);
    chk("t6_settle_dbl", dbl, 0);
    chk("t6_settle_bcd", int'(bcd), 9);

    // reset then 00 first: committed as blank
    rst_n = 1'b0;
    seg   = 7'h00;
    step();
    rst_n = 1'b1;
    run(40, pulses, first, dbl, xs);
    chk("t6_blank_first_p", pulses, 1);
    chk("t6_blank_first", int'({bcd, blank, err}), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
